// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder computing {co, s} = a + b + ci.
// DIGIT bits are added per clock through a single DIGIT-wide ripple slice and
// a carry register, so a result takes NSTEPS = WIDTH/DIGIT clocks.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake (a, b, ci sampled on accept)
//   a, b, ci            operands and carry-in
//   out_valid, out_ready result handshake (s, co, err held while waiting)
//   s, co               sum and carry-out
//   err                 sticky DMR mismatch flag
//
// Build option: define SERIAL_ADDER_DMR_EN to add a redundant slice and carry
// register that shadow every step; any disagreement sets err. Without it err
// is tied to 0.
//
// WIDTH must be >= 1 and DIGIT must divide WIDTH exactly.
module serial_adder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             err
);

   localparam int unsigned NSTEPS = WIDTH / DIGIT;
   localparam int unsigned CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
   localparam logic [CW-1:0] LastStep = CW'(NSTEPS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept;
   logic [DIGIT-1:0] slice_sum;
   logic             slice_co;
   logic [WIDTH+DIGIT-1:0] s_cat;

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign accept    = in_valid & in_ready;

   // The one ripple slice: low digit of each operand plus the running carry.
   assign {slice_co, slice_sum} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                                + {{DIGIT{1'b0}}, carry_q};

   // New sum digit enters at the top; after NSTEPS shifts the first digit is
   // at the bottom. Concatenation keeps this legal when DIGIT == WIDTH.
   assign s_cat = {slice_sum, s_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = ci;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            s_d     = s_cat[WIDTH+DIGIT-1:DIGIT];
            carry_d = slice_co;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LastStep) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   // In DONE the carry register holds the final carry-out.
   assign s  = s_q;
   assign co = carry_q;

`ifdef SERIAL_ADDER_DMR_EN
   logic             dmr_carry_q, dmr_carry_d;
   logic             err_q, err_d;
   logic [DIGIT-1:0] dmr_sum;
   logic             dmr_co;

   // Shadow slice fed from the same operand digits but its own carry chain.
   assign {dmr_co, dmr_sum} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                            + {{DIGIT{1'b0}}, dmr_carry_q};

   always_comb begin
      dmr_carry_d = dmr_carry_q;
      err_d       = err_q;
      if (accept) begin
         dmr_carry_d = ci;
         err_d       = 1'b0;
      end else if (state_q == StRun) begin
         dmr_carry_d = dmr_co;
         err_d       = err_q | (dmr_sum != slice_sum) | (dmr_co != slice_co);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmr_carry_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         dmr_carry_q <= dmr_carry_d;
         err_q       <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit/1-bit-digit instance and a
// 4-bit/2-bit-digit instance swept over every operand combination.
module tb_serial_adder;

   logic       clk;
   logic       rst_n;

   logic       iv8, ir8, ci8, ov8, or8, co8, err8;
   logic [7:0] a8, b8, s8;

   logic       iv4, ir4, ci4, ov4, or4, co4, err4;
   logic [3:0] a4, b4, s4;

   int checks;
   int passes;

   serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (iv8),
      .in_ready (ir8),
      .a        (a8),
      .b        (b8),
      .ci       (ci8),
      .out_valid(ov8),
      .out_ready(or8),
      .s        (s8),
      .co       (co8),
      .err      (err8)
   );

   serial_adder #(.WIDTH(4), .DIGIT(2)) dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (iv4),
      .in_ready (ir4),
      .a        (a4),
      .b        (b4),
      .ci       (ci4),
      .out_valid(ov4),
      .out_ready(or4),
      .s        (s4),
      .co       (co4),
      .err      (err4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One 8-bit operation: accept, wait for result, hold for 'stall' cycles,
   // then retire. Operand inputs are scrambled right after the accept.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic eco, input int stall);
      int n;
      @(negedge clk);
      check("idle_in_ready", {31'd0, ir8}, 32'd1);
      iv8 = 1'b1; a8 = a; b8 = b; ci8 = c; or8 = 1'b0;
      @(posedge clk); #1;
      iv8 = 1'b0; a8 = ~a; b8 = ~b; ci8 = ~c;
      check("run_in_ready", {31'd0, ir8}, 32'd0);
      n = 0;
      while (!ov8 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency8", n, 32'd8);
      check("sum8", {23'd0, co8, s8}, {23'd0, eco, es});
`ifndef SERIAL_ADDER_DMR_EN
      check("err8_zero", {31'd0, err8}, 32'd0);
`endif
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         check("hold8", {22'd0, ov8, co8, s8}, {22'd0, 1'b1, eco, es});
      end
      @(negedge clk); or8 = 1'b1;
      @(posedge clk); #1; or8 = 1'b0;
      check("retire8", {30'd0, ov8, ir8}, 32'd1);
   endtask

   initial begin
      logic [4:0] exp5;
      logic [3:0] ea, eb;
      logic       ec;
      int         n;
      int         gap;
      int         bad;

      checks = 0;
      passes = 0;
      iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; or8 = 1'b0;
      iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1; or4 = 1'b0;
      rst_n = 1'b0;

      // Reset held with in_valid high: nothing is accepted.
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, ir8}, 32'd1);
      check("rst_out_valid", {31'd0, ov8}, 32'd0);
      check("rst_s", {24'd0, s8}, 32'd0);
      check("rst_co", {31'd0, co8}, 32'd0);
      check("rst_err", {31'd0, err8}, 32'd0);
      check("rst4", {25'd0, ir4, ov4, co4, s4}, {25'd0, 1'b1, 1'b0, 1'b0, 4'h0});
      @(negedge clk);
      iv8 = 1'b0; iv4 = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_idle", {31'd0, ir8}, 32'd1);

      // Basic add with 3 cycles of backpressure.
      op8(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 3);
      // Wrap-around cases.
      op8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0);
      op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1);
      op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0);

      // Reset during step 3 of 8 aborts the operation.
      @(negedge clk);
      iv8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; ci8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_idle", {30'd0, ir8, ov8}, 32'd2);
      check("abort_s", {23'd0, co8, s8}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (ov8 !== 1'b0) bad++;
      end
      check("abort_no_result", bad, 32'd0);
      op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

`ifdef SERIAL_ADDER_DMR_EN
      // Corrupt the shadow carry at step 2 of a 0+0+0 add.
      @(negedge clk);
      iv8 = 1'b1; a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
      @(posedge clk); #1;
      iv8 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      force dut8.dmr_carry_q = 1'b1;
      @(posedge clk); #1;
      release dut8.dmr_carry_q;
      n = 0;
      while (!ov8 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("dmr_valid", {31'd0, ov8}, 32'd1);
      check("dmr_err_set", {31'd0, err8}, 32'd1);
      check("dmr_sum", {23'd0, co8, s8}, 32'd0);
      @(negedge clk); or8 = 1'b1;
      @(posedge clk); #1; or8 = 1'b0;
      @(negedge clk);
      iv8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; ci8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      check("dmr_err_clear", {31'd0, err8}, 32'd0);
      n = 0;
      while (!ov8 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("dmr_clean_err", {31'd0, err8}, 32'd0);
      check("dmr_clean_sum", {23'd0, co8, s8}, {23'd0, 1'b0, 8'h97});
      @(negedge clk); or8 = 1'b1;
      @(posedge clk); #1; or8 = 1'b0;
`endif

      // Exhaustive 4-bit/2-bit-digit sweep; in_valid stays high through DONE.
      for (int i = 0; i < 512; i++) begin
         ea = i[3:0];
         eb = i[7:4];
         ec = i[8];
         exp5 = {1'b0, ea} + {1'b0, eb} + {4'd0, ec};
         @(negedge clk);
         iv4 = 1'b1; a4 = ea; b4 = eb; ci4 = ec; or4 = 1'b0;
         @(posedge clk); #1;
         a4 = ~ea; b4 = ~eb; ci4 = ~ec;
         n = 0;
         while (!ov4 && n < 10) begin
            @(posedge clk); #1;
            n++;
         end
         check("latency4", n, 32'd2);
         gap = $urandom_range(0, 2);
         repeat (gap) @(posedge clk);
         #1;
         check("sum4", {26'd0, ov4, co4, s4}, {26'd0, 1'b1, exp5});
         check("err4_zero_or_clean", {31'd0, err4}, 32'd0);
         @(negedge clk); or4 = 1'b1;
         @(posedge clk); #1;
         or4 = 1'b0; iv4 = 1'b0;
         check("retire4", {30'd0, ov4, ir4}, 32'd1);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
